// File: rtl/cla_addsub_pipe.sv
// rtl/cla_addsub_pipe.sv - pipelined carry-lookahead add/subtract unit with NZCV flags
//
// Purpose:
//   WIDTH-bit add/subtract built from GROUP-bit lookahead groups. The carry
//   chain is split across STAGES register stages, each resolving
//   ceil(NG/STAGES) groups. Valid/ready handshakes are on both sides, with a
//   synchronous flush.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      clears every in-flight operation at the next edge
//   in_valid   a/b/op/cin present this cycle
//   in_ready   unit accepts an operation this cycle
//   a, b       operands (WIDTH)
//   op         00 ADD, 01 SUB, 10 ADC, 11 SBC
//   cin        carry in (ADC/SBC only)
//   out_valid  sum/flags valid
//   out_ready  downstream accepts the result
//   sum        result (WIDTH)
//   flag_n/z/c/v  negative, zero, carry out, signed overflow
module cla_addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int NG  = WIDTH / GROUP;
  localparam int GPS = (NG + STAGES - 1) / STAGES;

  // One in-flight operation: operands, partial sum and the carry into the
  // next unresolved group.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] be;
    logic [WIDTH-1:0] s;
    logic             c;
  } word_t;

  function automatic int grp_hi(input int s);
    return ((s + 1) * GPS > NG) ? NG : (s + 1) * GPS;
  endfunction

  // Resolve groups [lo, hi). Each bit carry is formed in two-level lookahead
  // form (OR of generate terms times propagate products) rather than rippled.
  function automatic word_t step(input word_t w, input int lo, input int hi);
    word_t            r;
    logic [GROUP-1:0] gg;
    logic [GROUP-1:0] pp;
    logic [GROUP:0]   cc;
    logic             prod;
    r = w;
    for (int g = 0; g < NG; g++) begin
      if (g >= lo && g < hi) begin
        gg    = w.a[g*GROUP +: GROUP] & w.be[g*GROUP +: GROUP];
        pp    = w.a[g*GROUP +: GROUP] ^ w.be[g*GROUP +: GROUP];
        cc    = '0;
        cc[0] = r.c;
        for (int i = 1; i <= GROUP; i++) begin
          prod = 1'b1;
          for (int j = i - 1; j >= 0; j--) begin
            cc[i] = cc[i] | (gg[j] & prod);
            prod  = prod & pp[j];
          end
          cc[i] = cc[i] | (cc[0] & prod);
        end
        r.s[g*GROUP +: GROUP] = pp ^ cc[GROUP-1:0];
        r.c                   = cc[GROUP];
      end
    end
    return r;
  endfunction

  // Flags in {n, z, c, v} order.
  function automatic logic [3:0] flags_of(input word_t w);
    logic v;
    v = (w.a[WIDTH-1] == w.be[WIDTH-1]) & (w.s[WIDTH-1] != w.a[WIDTH-1]);
    return {w.s[WIDTH-1], ~|w.s, w.c, v};
  endfunction

  word_t              prep;
  word_t              stage_d [STAGES];
  word_t              stage_q [STAGES];
  logic [STAGES-1:0]  v_q;
  logic [STAGES-1:0]  adv;
  logic [STAGES-1:0]  ld;
  logic               go;
  logic [3:0]         flags;

  always_comb begin
    prep.a  = a;
    prep.be = op[0] ? ~b : b;
    prep.s  = '0;
    prep.c  = op[1] ? cin : op[0];
    stage_d[0] = step(prep, 0, grp_hi(0));
    for (int s = 1; s < STAGES; s++) begin
      stage_d[s] = step(stage_q[s-1], s * GPS, grp_hi(s));
    end
  end

  // Walk from the output back to the input: go means "the stage downstream
  // of s can take a word this cycle". After the loop it is stage 0's slot.
  always_comb begin
    adv = '0;
    ld  = '0;
    go  = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      adv[s] = v_q[s] & go;
      go     = ~v_q[s] | go;
    end
    ld[0] = in_valid & go & ~flush;
    for (int s = 1; s < STAGES; s++) begin
      ld[s] = adv[s-1] & ~flush;
    end
  end

  assign in_ready = flush | go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        stage_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (flush) begin
          v_q[s] <= 1'b0;
        end else if (ld[s]) begin
          v_q[s]     <= 1'b1;
          stage_q[s] <= stage_d[s];
        end else if (adv[s]) begin
          v_q[s] <= 1'b0;
        end
      end
    end
  end

  // Flags are forced low whenever no result is presented, so reset shows zero.
  assign out_valid = v_q[STAGES-1];
  assign sum       = stage_q[STAGES-1].s;
  assign flags     = flags_of(stage_q[STAGES-1]) & {4{out_valid}};
  assign flag_n    = flags[3];
  assign flag_z    = flags[2];
  assign flag_c    = flags[1];
  assign flag_v    = flags[0];

endmodule
